// File: rtl/riscv_cpu_mc.sv
// Multi-cycle RV32I/RV32E core sharing one request/ready memory port for fetch, load and store.
// The control FSM owns pc, bus outputs and counters; datapath registers carry no reset.
module riscv_cpu_mc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          REG_COUNT = 32,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  output logic [31:0]      pc,
  output logic [31:0]      result,
  output logic [CNT_W-1:0] instret,
  output logic             halted
);

  if (REG_COUNT != 32 && REG_COUNT != 16) begin : g_bad_reg_count
    $error("riscv_cpu_mc: REG_COUNT must be 16 or 32");
  end

  localparam int               RIDX_W  = (REG_COUNT == 16) ? 4 : 5;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  state_e           state_q;
  logic [31:0]      pc_q, mem_addr_q, mem_wdata_q, result_q;
  logic             mem_req_q, mem_we_q, halted_q;
  logic [CNT_W-1:0] instret_q;

  logic [31:0] ir_q, a_q, b_q, wb_q, npc_q;
  logic [31:0] regs_q [REG_COUNT];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, pc4;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'd0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign pc4    = pc_q + 32'd4;

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1[RIDX_W-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2[RIDX_W-1:0]];

  // Legality only inspects the register fields the format actually uses.
  logic legal, use_rd, use_rs1, use_rs2;
  always_comb begin
    legal   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: begin legal = 1'b1; use_rd = 1'b1; end
      OP_JALR: begin legal = (f3 == 3'd0); use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_BR:   begin legal = (f3 != 3'd2) && (f3 != 3'd3); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_LD:   begin legal = (f3 == 3'd2); use_rd = 1'b1; use_rs1 = 1'b1; end
      OP_ST:   begin legal = (f3 == 3'd2); use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_IMM: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                 legal = 1'b1;
      end
      OP_OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        legal   = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
      default: legal = 1'b0;
    endcase
    if (REG_COUNT == 16 && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4])))
      legal = 1'b0;
  end

  logic [31:0]        op2, alu, exec_val, next_pc, br_tgt, jal_tgt, jalr_tgt, ls_addr, br_next;
  logic signed [31:0] a_s, b_s, op2_s, sra_v;
  logic               taken, is_mem, exec_fault;
  always_comb begin
    op2   = (opcode == OP_OP) ? b_q : imm_i;
    a_s   = a_q;
    b_s   = b_q;
    op2_s = op2;
    sra_v = a_s >>> op2[4:0];
    case (f3)
      3'd0:    alu = (opcode == OP_OP && f7[5]) ? a_q - op2 : a_q + op2;
      3'd1:    alu = a_q << op2[4:0];
      3'd2:    alu = {31'd0, a_s < op2_s};
      3'd3:    alu = {31'd0, a_q < op2};
      3'd4:    alu = a_q ^ op2;
      3'd5:    alu = ir_q[30] ? sra_v : a_q >> op2[4:0];
      3'd6:    alu = a_q | op2;
      default: alu = a_q & op2;
    endcase
    case (f3)
      3'd0:    taken = (a_q == b_q);
      3'd1:    taken = (a_q != b_q);
      3'd4:    taken = (a_s < b_s);
      3'd5:    taken = (a_s >= b_s);
      3'd6:    taken = (a_q < b_q);
      3'd7:    taken = (a_q >= b_q);
      default: taken = 1'b0;
    endcase
    br_tgt   = pc_q + imm_b;
    jal_tgt  = pc_q + imm_j;
    jalr_tgt = (a_q + imm_i) & ~32'd1;
    br_next  = taken ? br_tgt : pc4;
    is_mem   = (opcode == OP_LD) || (opcode == OP_ST);
    ls_addr  = a_q + ((opcode == OP_ST) ? imm_s : imm_i);
    exec_fault = ((opcode == OP_BR) && taken && br_tgt[1]) ||
                 ((opcode == OP_JAL) && jal_tgt[1]) ||
                 ((opcode == OP_JALR) && jalr_tgt[1]) ||
                 (is_mem && (ls_addr[1:0] != 2'd0));
    case (opcode)
      OP_LUI:          exec_val = imm_u;
      OP_AUIPC:        exec_val = pc_q + imm_u;
      OP_JAL, OP_JALR: exec_val = pc4;
      default:         exec_val = alu;
    endcase
    case (opcode)
      OP_JAL:  next_pc = jal_tgt;
      OP_JALR: next_pc = jalr_tgt;
      default: next_pc = pc4;
    endcase
  end

  // Every transition into FETCH or MEM sets up the bus so it is stable for the whole request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      result_q    <= 32'd0;
      instret_q   <= '0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_FETCH;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= pc_q;
        end
        S_FETCH: if (mem_ready) begin
          mem_req_q <= 1'b0;
          state_q   <= S_DECODE;
        end
        S_DECODE: begin
          state_q  <= legal ? S_EXEC : S_HALT;
          halted_q <= ~legal;
        end
        S_EXEC: begin
          if (exec_fault) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else if (opcode == OP_BR) begin
            pc_q       <= br_next;
            instret_q  <= instret_q + CNT_ONE;
            state_q    <= S_FETCH;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= br_next;
          end else if (is_mem) begin
            state_q     <= S_MEM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= (opcode == OP_ST);
            mem_addr_q  <= ls_addr;
            mem_wdata_q <= b_q;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: if (mem_ready) begin
          mem_we_q <= 1'b0;
          if (mem_we_q) begin
            pc_q       <= pc4;
            instret_q  <= instret_q + CNT_ONE;
            state_q    <= S_FETCH;
            mem_addr_q <= pc4;
          end else begin
            mem_req_q <= 1'b0;
            state_q   <= S_WB;
          end
        end
        S_WB: begin
          if (rd != 5'd0) result_q <= wb_q;
          pc_q       <= npc_q;
          instret_q  <= instret_q + CNT_ONE;
          state_q    <= S_FETCH;
          mem_req_q  <= 1'b1;
          mem_we_q   <= 1'b0;
          mem_addr_q <= npc_q;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state_q)
      S_FETCH:  if (mem_ready) ir_q <= mem_rdata;
      S_DECODE: begin a_q <= rs1_val; b_q <= rs2_val; end
      S_EXEC:   begin wb_q <= exec_val; npc_q <= next_pc; end
      S_MEM:    if (mem_ready) wb_q <= mem_rdata;
      S_WB:     if (rd != 5'd0) regs_q[rd[RIDX_W-1:0]] <= wb_q;
      default:  ;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign result    = result_q;
  assign instret   = instret_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_riscv_cpu_mc.sv
// Scoreboard bench for riscv_cpu_mc: an RV32I core on a wait-stated memory and an RV32E core with a 4-bit counter.
module tb_riscv_cpu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // RV32I core, reset PC 0, configurable wait states
  logic        rst_n_a, mem_req_a, mem_we_a, mem_ready_a, halted_a;
  logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a, pc_a, result_a, instret_a;

  riscv_cpu_mc #(.RESET_PC(32'h0), .REG_COUNT(32), .CNT_W(32)) u_a (
    .clk(clk), .reset(rst_n_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
    .mem_ready(mem_ready_a), .pc(pc_a), .result(result_a), .instret(instret_a),
    .halted(halted_a)
  );

  // RV32E core, reset PC 0x100, 4-bit counter, ready held high
  logic        rst_n_e, mem_req_e, mem_we_e, halted_e;
  logic        mem_ready_e = 1'b1;
  logic [31:0] mem_addr_e, mem_wdata_e, mem_rdata_e, pc_e, result_e;
  logic [3:0]  instret_e;

  riscv_cpu_mc #(.RESET_PC(32'h100), .REG_COUNT(16), .CNT_W(4)) u_e (
    .clk(clk), .reset(rst_n_e), .mem_req(mem_req_e), .mem_we(mem_we_e),
    .mem_addr(mem_addr_e), .mem_wdata(mem_wdata_e), .mem_rdata(mem_rdata_e),
    .mem_ready(mem_ready_e), .pc(pc_e), .result(result_e), .instret(instret_e),
    .halted(halted_e)
  );

  logic [31:0] prog_a [0:255];
  logic [31:0] dmem_a [0:255];
  logic [31:0] prog_e [0:255];
  logic [255:0] dval_a;
  logic        clr_a = 1'b1;
  int          w_a = 0, wcnt_a = 0, wr_cnt_a = 0;
  logic [31:0] last_waddr_a = 0, last_wdata_a = 0;

  assign mem_rdata_a = dval_a[mem_addr_a[9:2]] ? dmem_a[mem_addr_a[9:2]] : prog_a[mem_addr_a[9:2]];
  assign mem_ready_a = mem_req_a && (wcnt_a >= w_a);
  assign mem_rdata_e = prog_e[mem_addr_e[9:2]];

  always @(posedge clk) begin
    if (clr_a) dval_a <= '0;
    if (!mem_req_a || mem_ready_a) wcnt_a <= 0;
    else wcnt_a <= wcnt_a + 1;
    if (mem_req_a && mem_ready_a && mem_we_a) begin
      dmem_a[mem_addr_a[9:2]] <= mem_wdata_a;
      dval_a[mem_addr_a[9:2]] <= 1'b1;
      wr_cnt_a     <= wr_cnt_a + 1;
      last_waddr_a <= mem_addr_a;
      last_wdata_a <= mem_wdata_a;
    end
  end

  // Bus stability while a request waits, and no requests while halted
  logic        pend_a = 1'b0;
  logic [64:0] held_a = '0;
  int          stab_viol = 0, halt_viol = 0;
  always @(posedge clk) begin
    pend_a <= mem_req_a && !mem_ready_a;
    held_a <= {mem_we_a, mem_addr_a, mem_wdata_a};
  end
  always @(negedge clk) begin
    if (pend_a && mem_req_a && ({mem_we_a, mem_addr_a, mem_wdata_a} != held_a)) stab_viol++;
    if ((halted_a && mem_req_a) || (halted_e && mem_req_e)) halt_viol++;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  task automatic push(input logic [31:0] epc, input logic [31:0] eres, input int ecyc);
    exp_t e;
    e.pc = epc; e.res = eres; e.cyc = ecyc;
    sb_q.push_back(e);
  endtask

  task automatic wait_ret_a(output int cyc, output bit ok);
    logic [31:0] prev;
    prev = instret_a;
    cyc = 0;
    ok = 1'b0;
    while (!ok && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (instret_a != prev) ok = 1'b1;
    end
  endtask

  task automatic run_sb_a(input string ph);
    exp_t e;
    int   c;
    bit   ok;
    int   n;
    n = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n++;
      wait_ret_a(c, ok);
      chk($sformatf("%s_retire%0d", ph, n), {31'd0, ok}, 32'd1);
      if (!ok) sb_q.delete();
      else begin
        chk($sformatf("%s_pc%0d", ph, n), pc_a, e.pc);
        chk($sformatf("%s_result%0d", ph, n), result_a, e.res);
        chk($sformatf("%s_cycles%0d", ph, n), c, e.cyc);
      end
    end
  endtask

  initial begin
    int          k;
    logic [31:0] prev;
    rst_n_a = 1'b0;
    rst_n_e = 1'b0;
    for (int i = 0; i < 256; i++) begin
      prog_a[i] = 32'h0;
      prog_e[i] = 32'h0;
    end

    // RV32E core: boot, counter wrap, illegal register fault
    prog_e[8'h40] = 32'h00100093;                           // addi x1,x0,1
    for (int i = 8'h41; i <= 8'h4F; i++) prog_e[i] = 32'h00108093; // addi x1,x1,1
    prog_e[8'h50] = 32'h002088B3;                           // add x17,x1,x2
    repeat (3) @(posedge clk);
    #1;
    chk("e_rst_pc", pc_e, 32'h100);
    chk("e_rst_req", mem_req_e, 0);
    chk("e_rst_instret", instret_e, 0);
    chk("e_rst_halted", halted_e, 0);
    @(negedge clk) rst_n_e = 1'b1;
    #1;
    chk("e_idle_req", mem_req_e, 0);
    @(posedge clk); #1;
    chk("e_boot_req", mem_req_e, 1);
    chk("e_boot_addr", mem_addr_e, 32'h100);
    chk("e_boot_we", mem_we_e, 0);
    for (int i = 1; i <= 16; i++) begin
      prev = {28'd0, instret_e};
      k = 0;
      while ({28'd0, instret_e} == prev && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      chk($sformatf("e_instret%0d", i), instret_e, i % 16);
    end
    chk("e_result16", result_e, 32'h10);
    chk("e_pc16", pc_e, 32'h140);
    repeat (10) @(posedge clk);
    #1;
    chk("e_rv32e_halted", halted_e, 1);
    chk("e_rv32e_pc", pc_e, 32'h140);
    chk("e_rv32e_instret", instret_e, 0);
    chk("e_rv32e_req", mem_req_e, 0);
    @(negedge clk) rst_n_e = 1'b0;
    #1;
    chk("e_rst_clears_halted", halted_e, 0);
    chk("e_rst_pc2", pc_e, 32'h100);

    // RV32I core, W=3: addi, sltu, then illegal opcode
    clr_a = 1'b0;
    w_a = 3;
    prog_a[0] = 32'hFFB00093;  // addi x1,x0,-5
    prog_a[1] = 32'h0000B133;  // sltu x2,x1,x0
    prog_a[2] = 32'h0000007F;  // illegal opcode
    push(32'h4, 32'hFFFFFFFB, 8);
    push(32'h8, 32'h0, 7);
    chk("a_rst_pc", pc_a, 0);
    chk("a_rst_req", mem_req_a, 0);
    chk("a_rst_result", result_a, 0);
    chk("a_rst_instret", instret_a, 0);
    @(negedge clk) rst_n_a = 1'b1;
    run_sb_a("w3");
    repeat (12) @(posedge clk);
    #1;
    chk("op7f_halted", halted_a, 1);
    chk("op7f_pc", pc_a, 32'h8);
    chk("op7f_instret", instret_a, 2);
    chk("op7f_req", mem_req_a, 0);

    // RV32I core, W=0: load/store, branch, jumps, x0, lui/srai, misaligned load
    @(negedge clk) rst_n_a = 1'b0;
    for (int i = 0; i < 256; i++) prog_a[i] = 32'h0;
    w_a = 0;
    prog_a[0]  = 32'hFFB00093;  // 00 addi x1,x0,-5
    prog_a[1]  = 32'h04000193;  // 04 addi x3,x0,0x40
    prog_a[2]  = 32'h0011A423;  // 08 sw x1,8(x3)
    prog_a[3]  = 32'h0081A203;  // 0C lw x4,8(x3)
    prog_a[4]  = 32'h00001463;  // 10 bne x0,x0,+8
    prog_a[5]  = 32'h03000313;  // 14 addi x6,x0,0x30
    prog_a[6]  = 32'h0080006F;  // 18 jal x0,+8
    prog_a[7]  = 32'h00130067;  // 1C jalr x0,1(x6)
    prog_a[8]  = 32'hFFDFF2EF;  // 20 jal x5,-4
    prog_a[12] = 32'h00700013;  // 30 addi x0,x0,7
    prog_a[13] = 32'h800003B7;  // 34 lui x7,0x80000
    prog_a[14] = 32'h41F3D413;  // 38 srai x8,x7,31
    prog_a[15] = 32'h0021A483;  // 3C lw x9,2(x3)
    push(32'h04, 32'hFFFFFFFB, 5);
    push(32'h08, 32'h00000040, 4);
    push(32'h0C, 32'h00000040, 4);
    push(32'h10, 32'hFFFFFFFB, 5);
    push(32'h14, 32'hFFFFFFFB, 3);
    push(32'h18, 32'h00000030, 4);
    push(32'h20, 32'h00000030, 4);
    push(32'h1C, 32'h00000024, 4);
    push(32'h30, 32'h00000024, 4);
    push(32'h34, 32'h00000024, 4);
    push(32'h38, 32'h80000000, 4);
    push(32'h3C, 32'hFFFFFFFF, 4);
    @(negedge clk) rst_n_a = 1'b1;
    run_sb_a("w0");
    repeat (10) @(posedge clk);
    #1;
    chk("sw_addr", last_waddr_a, 32'h48);
    chk("sw_wdata", last_wdata_a, 32'hFFFFFFFB);
    chk("sw_count", wr_cnt_a, 1);
    chk("lw42_halted", halted_a, 1);
    chk("lw42_pc", pc_a, 32'h3C);
    chk("lw42_instret", instret_a, 12);
    chk("lw42_req", mem_req_a, 0);

    // Reset while a store waits: nothing completes
    @(negedge clk) rst_n_a = 1'b0;
    for (int i = 0; i < 256; i++) prog_a[i] = 32'h0;
    prog_a[0] = 32'h0011A623;  // sw x1,12(x3)
    w_a = 5;
    @(negedge clk) rst_n_a = 1'b1;
    k = 0;
    while (!(mem_req_a && mem_we_a) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("midsw_req_seen", {31'd0, mem_req_a && mem_we_a}, 1);
    chk("midsw_addr", mem_addr_a, 32'h4C);
    chk("midsw_wdata", mem_wdata_a, 32'hFFFFFFFB);
    repeat (2) @(posedge clk);
    #2 rst_n_a = 1'b0;
    #1;
    chk("midsw_req_drop", mem_req_a, 0);
    chk("midsw_pc", pc_a, 0);
    chk("midsw_instret", instret_a, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("midsw_no_write", wr_cnt_a, 1);
    chk("midsw_word_untouched", {31'd0, dval_a[8'h13]}, 0);

    chk("bus_stable_viol", stab_viol, 0);
    chk("halt_req_viol", halt_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
